// File: rtl/instr_fetch.sv
// Instruction fetch stage: requests one word at PC, holds it until decode accepts,
// then advances PC sequentially or to a jump/branch target.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        jump,
    input  logic        branchTaken,
    output logic [31:0] pc,
    output logic [31:0] linkAddr
);

    typedef enum logic {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } state_t;

    localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    // Keeps imem_req low until the first edge after reset has been released.
    logic        armed_q;

    logic [31:0] pc4;
    logic [31:0] branch_off;
    logic [31:0] pc_next;

    assign pc4        = pc_q + 32'd4;
    assign branch_off = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};

    always_comb begin
        pc_next = pc4;
        if (jump) begin
            pc_next = {pc4[31:28], instr_q[25:0], 2'b00};
        end else if (branchTaken) begin
            pc_next = pc4 + branch_off;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        instr_d     = instr_q;
        imem_req    = (state_q == FETCH) && armed_q;
        instr_valid = (state_q == HOLD);
        case (state_q)
            FETCH: begin
                if (imem_req && imem_ack) begin
                    instr_d = imem_rdata;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (instr_ready) begin
                    pc_d    = pc_next;
                    state_d = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC_ALIGNED;
            instr_q <= 32'h0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            armed_q <= 1'b1;
        end
    end

    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign instr     = instr_q;
    assign linkAddr  = pc4;

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: driver issues fetch/accept traffic and pushes
// expectations; a negedge monitor pops and compares whatever the DUT presents.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic        jump;
    logic        branchTaken;
    logic [31:0] pc;
    logic [31:0] linkAddr;

    // Second instance with an unaligned, high reset PC.
    logic        imem_req2;
    logic [31:0] imem_addr2;
    logic        imem_ack2;
    logic [31:0] imem_rdata2;
    logic [31:0] instr2;
    logic        instr_valid2;
    logic        instr_ready2;
    logic        jump2;
    logic        branch2;
    logic [31:0] pc2;
    logic [31:0] link2;

    always #5 clk = ~clk;

    instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .jump(jump), .branchTaken(branchTaken),
        .pc(pc), .linkAddr(linkAddr)
    );

    instr_fetch #(.RESET_PC(32'h1000_0003)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req2), .imem_addr(imem_addr2),
        .imem_ack(imem_ack2), .imem_rdata(imem_rdata2),
        .instr(instr2), .instr_valid(instr_valid2), .instr_ready(instr_ready2),
        .jump(jump2), .branchTaken(branch2),
        .pc(pc2), .linkAddr(link2)
    );

    typedef struct {
        logic [31:0] word;
        logic [31:0] addr;
    } exp_t;

    exp_t        exp_instr_q[$];
    logic [31:0] exp_addr_q[$];
    logic [31:0] model_pc;
    bit          mon_en = 1'b0;
    int          n_checks = 0;
    int          n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference next-PC rule, written as plain arithmetic on the accepted word.
    function automatic logic [31:0] ref_next(input logic [31:0] cur, input logic [31:0] word,
                                             input bit j, input bit b);
        logic [31:0] p4;
        int          off;
        p4  = cur + 32'd4;
        off = int'($signed(word[15:0]));
        if (j)      return (p4 & 32'hF000_0000) | ((word & 32'h03FF_FFFF) << 2);
        else if (b) return p4 + 32'(off * 4);
        else        return p4;
    endfunction

    // Monitor: pops an address expectation at each new request and an
    // instruction expectation at each new valid, then checks every cycle.
    initial begin
        bit          req_seen;
        bit          val_seen;
        logic [31:0] cur_addr;
        exp_t        cur;
        req_seen = 1'b0;
        val_seen = 1'b0;
        cur_addr = 32'h0;
        cur      = '{32'h0, 32'h0};
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                req_seen = 1'b0;
                val_seen = 1'b0;
            end else begin
                if (imem_req) begin
                    if (!req_seen) begin
                        if (exp_addr_q.size() == 0) chk("addr_queue_empty", 32'd0, 32'd1);
                        else cur_addr = exp_addr_q.pop_front();
                        req_seen = 1'b1;
                    end
                    chk("imem_addr", imem_addr, cur_addr);
                end else begin
                    req_seen = 1'b0;
                end
                if (instr_valid) begin
                    if (!val_seen) begin
                        if (exp_instr_q.size() == 0) chk("instr_queue_empty", 32'd0, 32'd1);
                        else cur = exp_instr_q.pop_front();
                        val_seen = 1'b1;
                    end
                    chk("instr", instr, cur.word);
                    chk("pc", pc, cur.addr);
                    chk("linkAddr", linkAddr, cur.addr + 32'd4);
                end else begin
                    val_seen = 1'b0;
                end
                chk("req_and_valid", {31'b0, imem_req & instr_valid}, 32'd0);
            end
        end
    end

    // One full transaction: wait for req, ack after ack_dly cycles, stall
    // rdy_dly cycles (with spurious ack/jump/branch), then accept.
    task automatic do_fetch(input logic [31:0] data, input int ack_dly, input int rdy_dly,
                            input bit j, input bit b);
        int t;
        t = 0;
        while (!imem_req && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!imem_req) begin
            chk("req_timeout", {31'b0, imem_req}, 32'd1);
            return;
        end
        repeat (ack_dly) @(negedge clk);
        imem_ack   = 1'b1;
        imem_rdata = data;
        exp_instr_q.push_back('{data, model_pc});
        @(negedge clk);
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
        t = 0;
        while (!instr_valid && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!instr_valid) begin
            chk("valid_timeout", {31'b0, instr_valid}, 32'd1);
            return;
        end
        repeat (rdy_dly) begin
            imem_ack    = 1'b1;
            imem_rdata  = $urandom;
            jump        = 1'($urandom_range(0, 1));
            branchTaken = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        imem_ack    = 1'b0;
        instr_ready = 1'b1;
        jump        = j;
        branchTaken = b;
        model_pc    = ref_next(model_pc, data, j, b);
        exp_addr_q.push_back(model_pc);
        @(negedge clk);
        instr_ready = 1'b0;
        jump        = 1'($urandom_range(0, 1));
        branchTaken = 1'($urandom_range(0, 1));
    endtask

    initial begin
        rst_n        = 1'b0;
        imem_ack     = 1'b0;
        imem_rdata   = 32'h0;
        instr_ready  = 1'b0;
        jump         = 1'b0;
        branchTaken  = 1'b0;
        imem_ack2    = 1'b0;
        imem_rdata2  = 32'h0;
        instr_ready2 = 1'b0;
        jump2        = 1'b0;
        branch2      = 1'b0;
        model_pc     = 32'h0;

        repeat (3) @(negedge clk);
        chk("rst_req", {31'b0, imem_req}, 32'd0);
        chk("rst_valid", {31'b0, instr_valid}, 32'd0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_pc", pc, 32'h0);
        chk("rst_pc2_aligned", pc2, 32'h1000_0000);

        exp_addr_q.push_back(32'h0);
        mon_en = 1'b1;
        rst_n  = 1'b1;
        @(negedge clk);
        chk("req_after_release", {31'b0, imem_req}, 32'd1);

        // Directed path: first fetch, long stall, sequential, jump, branch, wrap.
        do_fetch(32'h2001_0005, 1, 5, 1'b0, 1'b0);   // 0 -> 4
        do_fetch($urandom, 0, 0, 1'b0, 1'b0);        // 4 -> 8
        do_fetch($urandom, 0, 0, 1'b0, 1'b0);        // 8 -> C
        do_fetch(32'h0800_0040, 0, 0, 1'b1, 1'b0);   // C -> 100
        do_fetch(32'h1000_FFFE, 0, 1, 1'b0, 1'b1);   // 100 -> FC
        do_fetch(32'h0800_0040, 2, 0, 1'b1, 1'b0);   // FC -> 100
        do_fetch(32'h1000_FFFE, 0, 0, 1'b0, 1'b0);   // 100 -> 104
        do_fetch(32'h0800_0000, 0, 0, 1'b1, 1'b0);   // 104 -> 0
        do_fetch(32'h1000_FFFE, 0, 0, 1'b0, 1'b1);   // 0 -> FFFFFFFC
        do_fetch($urandom, 0, 0, 1'b0, 1'b0);        // FFFFFFFC -> 0

        for (int i = 0; i < 60; i++) begin
            do_fetch($urandom, $urandom_range(0, 3), $urandom_range(0, 3),
                     ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0));
        end

        // Reset while waiting in FETCH at 0x40, with ack during and after reset.
        mon_en = 1'b0;
        @(negedge clk);
        exp_addr_q.delete();
        exp_instr_q.delete();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        model_pc = 32'h0;
        exp_addr_q.push_back(32'h0);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        do_fetch(32'h0800_0010, 0, 0, 1'b1, 1'b0);   // 0 -> 40
        @(negedge clk);
        chk("wait_at_40", imem_addr, 32'h0000_0040);
        mon_en     = 1'b0;
        rst_n      = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        repeat (2) begin
            @(negedge clk);
            chk("rst_mid_req", {31'b0, imem_req}, 32'd0);
            chk("rst_mid_valid", {31'b0, instr_valid}, 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        imem_ack = 1'b0;
        repeat (3) begin
            chk("restart_addr", imem_addr, 32'h0);
            chk("restart_req", {31'b0, imem_req}, 32'd1);
            chk("restart_valid", {31'b0, instr_valid}, 32'd0);
            @(negedge clk);
        end
        exp_addr_q.delete();
        exp_instr_q.delete();
        model_pc = 32'h0;
        exp_addr_q.push_back(32'h0);
        mon_en = 1'b1;
        do_fetch(32'h1234_5678, 1, 0, 1'b0, 1'b0);
        do_fetch($urandom, 0, 0, 1'b0, 1'b0);
        @(negedge clk);
        mon_en = 1'b0;

        // High-region jump with branchTaken also set: jump wins.
        chk("dut2_req", {31'b0, imem_req2}, 32'd1);
        chk("dut2_addr", imem_addr2, 32'h1000_0000);
        imem_ack2   = 1'b1;
        imem_rdata2 = 32'h0800_00FA;
        @(negedge clk);
        imem_ack2 = 1'b0;
        chk("dut2_valid", {31'b0, instr_valid2}, 32'd1);
        chk("dut2_instr", instr2, 32'h0800_00FA);
        chk("dut2_link", link2, 32'h1000_0004);
        instr_ready2 = 1'b1;
        jump2        = 1'b1;
        branch2      = 1'b1;
        @(negedge clk);
        instr_ready2 = 1'b0;
        jump2        = 1'b0;
        branch2      = 1'b0;
        chk("dut2_jump_addr", imem_addr2, 32'h1000_03E8);
        chk("dut2_valid_drop", {31'b0, instr_valid2}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
